branch_redirect_ctrl: RTL and testbench



---
 rtl/branch_ctrl_pkg.sv | 12 +
 rtl/sat_counter.sv | 19 +
 rtl/branch_redirect_ctrl.sv | 95 +++++++++
 tb/tb_branch_redirect_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the branch redirect controller.
package branch_ctrl_pkg;

    localparam int WORD_W = 32;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Enabled up-counter that holds at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Turns a taken EX-stage branch into a fetch redirect handshake plus IF/ID and ID/EX flushes.
// Optional statistics counters are enabled by defining BRANCH_REDIRECT_STATS_EN.
module branch_redirect_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int PC_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_pcsel,
    input  logic [WORD_W-1:0] ex_brpc,
    input  logic              stall,
    input  logic              fetch_ready,
    output logic              redir_valid,
    output logic [PC_W-1:0]   redir_pc,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              busy,
    output logic              align_err,
    output logic              range_err
`ifdef BRANCH_REDIRECT_STATS_EN
    ,
    output logic [WORD_W-1:0] taken_cnt,
    output logic [WORD_W-1:0] stall_cyc_cnt
`endif
);

    state_e state;
    logic   capture;
    logic   bad_align;
    logic   bad_range;

    assign capture   = (state == IDLE) && ex_valid && ex_pcsel && !stall;
    assign bad_align = (ex_brpc[1:0] & ALIGN_MASK) != 2'b00;
    assign bad_range = ex_brpc[WORD_W-1:PC_W] != '0;

    // Every handshake output is a pure decode of state, so no input reaches an output combinationally.
    assign redir_valid = (state == REDIRECT);
    assign flush_ifid  = (state == REDIRECT);
    assign flush_idex  = (state == REDIRECT);
    assign busy        = (state == REDIRECT);

    // redir_pc is only written on a legal capture, which keeps it stable throughout REDIRECT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            redir_pc  <= '0;
            align_err <= 1'b0;
            range_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture) begin
                        if (bad_align) align_err <= 1'b1;
                        if (bad_range) range_err <= 1'b1;
                        if (!bad_align && !bad_range) begin
                            redir_pc <= ex_brpc[PC_W-1:0];
                            state    <= REDIRECT;
                        end
                    end
                end
                REDIRECT: begin
                    if (fetch_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BRANCH_REDIRECT_STATS_EN
    logic taken_en;
    logic stall_en;

    assign taken_en = capture && !bad_align && !bad_range;
    assign stall_en = (state == REDIRECT) && !fetch_ready;

    sat_counter #(.W(WORD_W)) u_taken_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (taken_en),
        .cnt   (taken_cnt)
    );

    sat_counter #(.W(WORD_W)) u_stall_cyc_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (stall_en),
        .cnt   (stall_cyc_cnt)
    );
`else
    // Statistics disabled: no counter state exists in this build.
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Table-driven, scoreboarded bench for branch_redirect_ctrl (PC_W = 9).
module tb_branch_redirect_ctrl;

    localparam int PC_W = 9;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            ex_valid = 1'b0;
    logic            ex_pcsel = 1'b0;
    logic [31:0]     ex_brpc = '0;
    logic            stall = 1'b0;
    logic            fetch_ready = 1'b0;
    logic            redir_valid;
    logic [PC_W-1:0] redir_pc;
    logic            flush_ifid;
    logic            flush_idex;
    logic            busy;
    logic            align_err;
    logic            range_err;
`ifdef BRANCH_REDIRECT_STATS_EN
    logic [31:0]     taken_cnt;
    logic [31:0]     stall_cyc_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic            ex_valid;
        logic            ex_pcsel;
        logic [31:0]     ex_brpc;
        logic            stall;
        logic            fetch_ready;
        logic            exp_rv;
        logic [PC_W-1:0] exp_pc;
        logic            exp_ae;
        logic            exp_re;
    } vec_t;

    typedef struct {
        logic            rv;
        logic [PC_W-1:0] pc;
        logic            ae;
        logic            re;
    } exp_t;

    exp_t scoreboard[$];
    vec_t table_v[19];

    branch_redirect_ctrl #(.PC_W(PC_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .ex_valid    (ex_valid),
        .ex_pcsel    (ex_pcsel),
        .ex_brpc     (ex_brpc),
        .stall       (stall),
        .fetch_ready (fetch_ready),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .flush_ifid  (flush_ifid),
        .flush_idex  (flush_idex),
        .busy        (busy),
        .align_err   (align_err),
        .range_err   (range_err)
`ifdef BRANCH_REDIRECT_STATS_EN
        ,
        .taken_cnt     (taken_cnt),
        .stall_cyc_cnt (stall_cyc_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input logic ps, input logic [31:0] pc,
                                input logic st, input logic fr, input logic rv,
                                input logic [PC_W-1:0] epc, input logic ae, input logic re);
        vec_t r;
        r.ex_valid = v;  r.ex_pcsel = ps; r.ex_brpc = pc; r.stall = st; r.fetch_ready = fr;
        r.exp_rv = rv;   r.exp_pc = epc;  r.exp_ae = ae;  r.exp_re = re;
        return r;
    endfunction

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        @(negedge clk);
        ex_valid = v.ex_valid; ex_pcsel = v.ex_pcsel; ex_brpc = v.ex_brpc;
        stall = v.stall; fetch_ready = v.fetch_ready;
        e.rv = v.exp_rv; e.pc = v.exp_pc; e.ae = v.exp_ae; e.re = v.exp_re;
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (scoreboard.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s scoreboard: got empty queue expected an entry", tag);
            return;
        end
        e = scoreboard.pop_front();
        checkField({tag, " redir_valid"}, {31'd0, redir_valid}, {31'd0, e.rv});
        checkField({tag, " flush_ifid"},  {31'd0, flush_ifid},  {31'd0, e.rv});
        checkField({tag, " flush_idex"},  {31'd0, flush_idex},  {31'd0, e.rv});
        checkField({tag, " busy"},        {31'd0, busy},        {31'd0, e.rv});
        checkField({tag, " redir_pc"},    {23'd0, redir_pc},    {23'd0, e.pc});
        checkField({tag, " align_err"},   {31'd0, align_err},   {31'd0, e.ae});
        checkField({tag, " range_err"},   {31'd0, range_err},   {31'd0, e.re});
    endtask

    task automatic checkAllZero(input string tag);
        checkField({tag, " redir_valid"}, {31'd0, redir_valid}, 32'd0);
        checkField({tag, " flush_ifid"},  {31'd0, flush_ifid},  32'd0);
        checkField({tag, " flush_idex"},  {31'd0, flush_idex},  32'd0);
        checkField({tag, " busy"},        {31'd0, busy},        32'd0);
        checkField({tag, " redir_pc"},    {23'd0, redir_pc},    32'd0);
        checkField({tag, " align_err"},   {31'd0, align_err},   32'd0);
        checkField({tag, " range_err"},   {31'd0, range_err},   32'd0);
`ifdef BRANCH_REDIRECT_STATS_EN
        checkField({tag, " taken_cnt"},     taken_cnt,     32'd0);
        checkField({tag, " stall_cyc_cnt"}, stall_cyc_cnt, 32'd0);
`endif
    endtask

    task automatic doReset();
        @(negedge clk);
        ex_valid = 1'b0; ex_pcsel = 1'b0; ex_brpc = '0; stall = 1'b0; fetch_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        scoreboard.delete();
    endtask

    initial begin
        //                v  ps pc            st fr  rv pc      ae re
        table_v[0]  = mk(0, 0, 32'h0000_0000, 0, 0,  0, 9'h000, 0, 0);
        table_v[1]  = mk(1, 1, 32'h0000_0040, 0, 1,  1, 9'h040, 0, 0);
        table_v[2]  = mk(0, 0, 32'h0000_0000, 0, 1,  0, 9'h040, 0, 0);
        table_v[3]  = mk(1, 1, 32'h0000_0040, 0, 0,  1, 9'h040, 0, 0);
        table_v[4]  = mk(1, 1, 32'h0000_0080, 0, 0,  1, 9'h040, 0, 0);
        table_v[5]  = mk(0, 0, 32'h0000_0000, 0, 0,  1, 9'h040, 0, 0);
        table_v[6]  = mk(0, 0, 32'h0000_0000, 1, 0,  1, 9'h040, 0, 0);
        table_v[7]  = mk(0, 0, 32'h0000_0000, 0, 1,  0, 9'h040, 0, 0);
        table_v[8]  = mk(1, 1, 32'h0000_0042, 0, 1,  0, 9'h040, 1, 0);
        table_v[9]  = mk(1, 1, 32'h0000_1000, 0, 1,  0, 9'h040, 1, 1);
        table_v[10] = mk(1, 1, 32'h0000_01FC, 0, 1,  1, 9'h1FC, 1, 1);
        table_v[11] = mk(0, 0, 32'h0000_0000, 0, 1,  0, 9'h1FC, 1, 1);
        table_v[12] = mk(1, 1, 32'h0000_0084, 1, 1,  0, 9'h1FC, 1, 1);
        table_v[13] = mk(1, 1, 32'h0000_0084, 1, 1,  0, 9'h1FC, 1, 1);
        table_v[14] = mk(1, 1, 32'h0000_0084, 0, 1,  1, 9'h084, 1, 1);
        table_v[15] = mk(1, 1, 32'h0000_0100, 0, 1,  0, 9'h084, 1, 1);
        table_v[16] = mk(1, 1, 32'h0000_0100, 0, 1,  1, 9'h100, 1, 1);
        table_v[17] = mk(1, 0, 32'h0000_0000, 0, 1,  0, 9'h100, 1, 1);
        table_v[18] = mk(0, 1, 32'h0000_0020, 0, 1,  0, 9'h100, 1, 1);

        $display("[TB] start");
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            applyStimulus(table_v[i]);
            checkOutput($sformatf("vec%0d", i));
`ifdef BRANCH_REDIRECT_STATS_EN
            if (i == 7) begin
                checkField("vec7 taken_cnt", taken_cnt, 32'd2);
                checkField("vec7 stall_cyc_cnt", stall_cyc_cnt, 32'd3);
            end
`endif
        end

        // Reset in the middle of a stalled redirect must drop everything without waiting for a clock edge.
        doReset();
        applyStimulus(mk(1, 1, 32'h0000_0040, 0, 0, 1, 9'h040, 0, 0));
        checkOutput("midrst capture");
        applyStimulus(mk(0, 0, 32'h0000_0000, 0, 0, 1, 9'h040, 0, 0));
        checkOutput("midrst hold");
        #2;
        reset = 1'b1;
        #1;
        checkAllZero("midrst async");
        @(negedge clk);
        reset = 1'b0;
        scoreboard.delete();

        doReset();
        applyStimulus(mk(1, 1, 32'h0000_1002, 0, 1, 0, 9'h000, 1, 1));
        checkOutput("both_err");

        doReset();
        applyStimulus(mk(1, 1, 32'h0000_1000, 0, 1, 0, 9'h000, 0, 1));
        checkOutput("range_only");
        applyStimulus(mk(1, 1, 32'h0000_0010, 0, 1, 1, 9'h010, 0, 1));
        checkOutput("range_sticky");
        applyStimulus(mk(0, 0, 32'h0000_0000, 0, 1, 0, 9'h010, 0, 1));
        checkOutput("range_done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
